router_buffered: RTL
====================

# router_buffered

Buffered, parametrised NoC mesh router and successor to the unbuffered `router`. It has five valid/ready channels: Local NI, North, South, East and West. Each input has a FIFO, packets are steered by deterministic XY routing, and each output has its own round-robin arbiter and registered output stage. One instance sits at every mesh node, between the node's network interface and its four neighbours.

## Interface
Parameters:
- `GRID_WIDTH`, 4: mesh is GRID_WIDTH x GRID_WIDTH; ≥2.
- `ROUTER_ROW`, 0: this node's row, width COORD_WIDTH.
- `ROUTER_COL`, 0: this node's column, width COORD_WIDTH.
- `FIFO_DEPTH`, 4: entries per input FIFO; power of two, ≥2.
- `APB_PACKET_WIDTH`, pa_noc::APB_PACKET_WIDTH: localparam.
- `COORD_WIDTH`, $clog2(GRID_WIDTH): localparam.

Ports:
- `i_clk`  in  1  sole clock.
- `i_arst_n`  in  1  reset, asynchronous assert, active-low.
- `i_apbPacket`/`i_apbPacketValid`/`o_apbPacketReady`  in/in/out  W/1/1  from NI.
- `o_apbPacket`/`o_apbPacketValid`/`i_apbPacketReady`  out/out/in  W/1/1  to NI.
- `i_north`/`i_northValid`/`o_northReady`  in/in/out  W/1/1  from North.
- `i_south`, `i_east`, `i_west` (+Valid/Ready): same shape as `i_north`.
- `o_north`/`o_northValid`/`i_northReady`  out/out/in  W/1/1  to North.
- `o_south`, `o_east`, `o_west` (+Valid/Ready): same shape as `o_north`.

## Operation
- Port index: LOCAL=0, NORTH=1, SOUTH=2, EAST=3, WEST=4.
- Destination field: row = packet[2*COORD_WIDTH-1:COORD_WIDTH], col = packet[COORD_WIDTH-1:0].
- Input side:
  - Transfer occurs on valid&&ready.
  - `o_*Ready` = !full of that input FIFO, taken from registered FIFO state.
  - Valid never depends on ready.
- Routing of each FIFO head, evaluated in this order:
  - col>ROUTER_COL → EAST.
  - col<ROUTER_COL → WEST.
  - row>ROUTER_ROW → SOUTH.
  - row<ROUTER_ROW → NORTH.
  - Otherwise → LOCAL.
  - Exception: any coordinate ≥GRID_WIDTH → LOCAL. No packet is ever dropped.
- Output side, one arbiter per output:
  - Requests come from all non-empty FIFO heads routed to that output.
  - The output register is free when !o_valid, or when o_valid&&i_ready this cycle.
  - If free and at least one request exists, grant exactly one: round-robin starting from the pointer.
  - Each input is granted to at most one output per cycle, which follows from its single route.
  - Grant pops that FIFO and loads the output register.
  - After a grant, pointer ← (granted+1) mod 5. With no grant the pointer holds.
- Output register:
  - o_valid is set on load.
  - o_valid clears on handshake when there is no simultaneous load.
  - Data and valid stay stable while o_valid&&!i_ready.
- FIFO edge cases:
  - Push and pop on a non-full FIFO in the same cycle: count unchanged.
  - Pop of the last entry with a same-cycle push: FIFO stays non-empty.
  - Pointers wrap modulo FIFO_DEPTH.
- Reset:
  - All FIFOs empty, all `o_*Valid`=0, all `o_*` data ='0, all pointers=0.
  - `o_*Ready` are 0 during reset and 1 from the first cycle after deassert.
  - Reset mid-transfer discards all buffered packets.

## Timing
- Latency: packet accepted at edge N → on output at N+2 (FIFO write, then arbitrate and register). Minimum is 2 cycles.
- Throughput: 1 packet/cycle per output; up to 5 packets/cycle aggregate with distinct outputs.
- Ready reflects fullness after the previous edge. No combinational ready→valid or ready→ready path.
- A FIFO holds at most FIFO_DEPTH packets. Ready goes low the cycle after the FIFO fills.
- Fairness: a persistently requesting input is granted within 5 grants of its output.

## Structure
- pa_noc additions:
  - `APB_PACKET_WIDTH` (exists).
  - Port index enum `port_e`.
  - `N_PORTS`=5.
  - Function `routeXY(dstRow, dstCol, rtrRow, rtrCol, gridWidth)` returning `port_e`.
- Sub-module `noc_fifo` (params `WIDTH`, `DEPTH`), instantiated 5×.
- Arbiter and output stage are inlined in a generate loop over outputs.

## Test plan
- Router (1,1), 4×4 grid; NI injects dest (1,3) → o_east carries the packet 2 cycles later, all other valids 0.
- Router (1,1); inject dest (3,1) from West → o_south. Inject dest (1,1) from North → o_apbPacket.
- East holds i_eastReady=0; 5 packets East-bound from Local, FIFO_DEPTH=4:
  - 4 packets are buffered plus 1 in the output register.
  - o_apbPacketReady=0.
  - On release, packets drain in order, 1/cycle, unchanged.
- All 5 inputs continuously send to LOCAL → grants rotate 0,1,2,3,4,0 with no starvation.
- Simultaneous N→S and S→N, E→W and W→E traffic → all four outputs valid in the same cycle.
- Assert i_arst_n=0 with full FIFOs mid-stream:
  - All valids 0 immediately.
  - After deassert, readies are 1 and no stale packet appears.

Source files
------------

// File: rtl/pa_noc.sv
// rtl/pa_noc.sv - NoC package: packet width, port indices and XY routing.
package pa_noc;

  localparam int APB_PACKET_WIDTH = 32;
  localparam int N_PORTS          = 5;

  typedef enum logic [2:0] {
    PORT_LOCAL = 3'd0,
    PORT_NORTH = 3'd1,
    PORT_SOUTH = 3'd2,
    PORT_EAST  = 3'd3,
    PORT_WEST  = 3'd4
  } port_e;

  // Column first, then row; out-of-grid destinations are delivered locally.
  function automatic port_e routeXY(input int unsigned dstRow, input int unsigned dstCol,
                                    input int unsigned rtrRow, input int unsigned rtrCol,
                                    input int unsigned gridWidth);
    if (dstRow >= gridWidth || dstCol >= gridWidth) return PORT_LOCAL;
    if (dstCol > rtrCol) return PORT_EAST;
    if (dstCol < rtrCol) return PORT_WEST;
    if (dstRow > rtrRow) return PORT_SOUTH;
    if (dstRow < rtrRow) return PORT_NORTH;
    return PORT_LOCAL;
  endfunction

endpackage

// File: rtl/noc_fifo.sv
// rtl/noc_fifo.sv - Input FIFO with registered ready (ready = not full next cycle).
module noc_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_arst_n,
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_valid,
  output logic             o_ready,
  output logic [WIDTH-1:0] o_data,
  output logic             o_empty,
  input  logic             i_pop
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_COUNT = (AW + 1)'(DEPTH);

  logic [AW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [AW:0]    count_q, count_d;
  logic           ready_q, ready_d;
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic           push;
  logic           pop;

  always_comb begin
    push     = i_valid && ready_q;
    pop      = i_pop && (count_q != '0);
    wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + AW'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (AW + 1)'(1);
      2'b01:   count_d = count_q - (AW + 1)'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != FULL_COUNT);
  end

  // ready_q resets low so nothing is accepted while reset is held.
  always_ff @(posedge i_clk or negedge i_arst_n) begin
    if (!i_arst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem_q[wr_ptr_q] <= i_data;
  end

  assign o_ready = ready_q;
  assign o_data  = mem_q[rd_ptr_q];
  assign o_empty = (count_q == '0);

endmodule

// File: rtl/router_buffered.sv
// rtl/router_buffered.sv - Buffered 5-port XY mesh router with per-output round-robin arbiters.
module router_buffered #(
  parameter int GRID_WIDTH = 4,
  parameter int ROUTER_ROW = 0,
  parameter int ROUTER_COL = 0,
  parameter int FIFO_DEPTH = 4,
  localparam int APB_PACKET_WIDTH = pa_noc::APB_PACKET_WIDTH,
  localparam int COORD_WIDTH = $clog2(GRID_WIDTH)
) (
  input  logic                        i_clk,
  input  logic                        i_arst_n,
  input  logic [APB_PACKET_WIDTH-1:0] i_apbPacket,
  input  logic                        i_apbPacketValid,
  output logic                        o_apbPacketReady,
  output logic [APB_PACKET_WIDTH-1:0] o_apbPacket,
  output logic                        o_apbPacketValid,
  input  logic                        i_apbPacketReady,
  input  logic [APB_PACKET_WIDTH-1:0] i_north,
  input  logic                        i_northValid,
  output logic                        o_northReady,
  input  logic [APB_PACKET_WIDTH-1:0] i_south,
  input  logic                        i_southValid,
  output logic                        o_southReady,
  input  logic [APB_PACKET_WIDTH-1:0] i_east,
  input  logic                        i_eastValid,
  output logic                        o_eastReady,
  input  logic [APB_PACKET_WIDTH-1:0] i_west,
  input  logic                        i_westValid,
  output logic                        o_westReady,
  output logic [APB_PACKET_WIDTH-1:0] o_north,
  output logic                        o_northValid,
  input  logic                        i_northReady,
  output logic [APB_PACKET_WIDTH-1:0] o_south,
  output logic                        o_southValid,
  input  logic                        i_southReady,
  output logic [APB_PACKET_WIDTH-1:0] o_east,
  output logic                        o_eastValid,
  input  logic                        i_eastReady,
  output logic [APB_PACKET_WIDTH-1:0] o_west,
  output logic                        o_westValid,
  input  logic                        i_westReady
);

  import pa_noc::N_PORTS;
  import pa_noc::port_e;
  import pa_noc::routeXY;

  localparam int W = APB_PACKET_WIDTH;

  logic [W-1:0]         in_data [N_PORTS];
  logic [N_PORTS-1:0]   in_valid;
  logic [N_PORTS-1:0]   in_ready;
  logic [N_PORTS-1:0]   out_ready;
  logic [N_PORTS-1:0]   fifo_empty;
  logic [N_PORTS-1:0]   pop;
  logic [W-1:0]         head [N_PORTS];
  port_e                route [N_PORTS];
  logic [N_PORTS-1:0]   grant [N_PORTS];  // grant[output][input]
  logic [W-1:0]         out_data_q [N_PORTS];
  logic                 out_valid_q [N_PORTS];

  assign in_data[0] = i_apbPacket;
  assign in_data[1] = i_north;
  assign in_data[2] = i_south;
  assign in_data[3] = i_east;
  assign in_data[4] = i_west;
  assign in_valid   = {i_westValid, i_eastValid, i_southValid, i_northValid, i_apbPacketValid};
  assign out_ready  = {i_westReady, i_eastReady, i_southReady, i_northReady, i_apbPacketReady};
  assign {o_westReady, o_eastReady, o_southReady, o_northReady, o_apbPacketReady} = in_ready;

  assign o_apbPacket      = out_data_q[0];
  assign o_north          = out_data_q[1];
  assign o_south          = out_data_q[2];
  assign o_east           = out_data_q[3];
  assign o_west           = out_data_q[4];
  assign o_apbPacketValid = out_valid_q[0];
  assign o_northValid     = out_valid_q[1];
  assign o_southValid     = out_valid_q[2];
  assign o_eastValid      = out_valid_q[3];
  assign o_westValid      = out_valid_q[4];

  for (genvar i = 0; i < N_PORTS; i++) begin : g_in
    noc_fifo #(
      .WIDTH(W),
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .i_clk   (i_clk),
      .i_arst_n(i_arst_n),
      .i_data  (in_data[i]),
      .i_valid (in_valid[i]),
      .o_ready (in_ready[i]),
      .o_data  (head[i]),
      .o_empty (fifo_empty[i]),
      .i_pop   (pop[i])
    );

    always_comb begin
      route[i] = routeXY(32'(head[i][2*COORD_WIDTH-1:COORD_WIDTH]),
                         32'(head[i][COORD_WIDTH-1:0]),
                         ROUTER_ROW, ROUTER_COL, GRID_WIDTH);
    end
  end

  // Each head has exactly one route, so at most one output can grant it.
  always_comb begin
    for (int i = 0; i < N_PORTS; i++) begin
      pop[i] = 1'b0;
      for (int o = 0; o < N_PORTS; o++) pop[i] = pop[i] | grant[o][i];
    end
  end

  for (genvar o = 0; o < N_PORTS; o++) begin : g_out
    logic [N_PORTS-1:0] req;
    logic [2:0]         ptr_q, ptr_d;
    logic [2:0]         sel;
    logic               found;
    logic               free;
    logic               load;
    logic               out_valid_d;
    logic [W-1:0]       out_data_d;

    always_comb begin
      for (int i = 0; i < N_PORTS; i++) begin
        req[i] = !fifo_empty[i] && (route[i] == port_e'(o));
      end
      free  = !out_valid_q[o] || out_ready[o];
      found = 1'b0;
      sel   = ptr_q;
      for (int k = 0; k < N_PORTS; k++) begin
        if (!found && req[(int'(ptr_q) + k) % N_PORTS]) begin
          found = 1'b1;
          sel   = 3'((int'(ptr_q) + k) % N_PORTS);
        end
      end
      load     = free && found;
      grant[o] = '0;
      if (load) grant[o][sel] = 1'b1;
      ptr_d = load ? ((sel == 3'(N_PORTS - 1)) ? 3'd0 : sel + 3'd1) : ptr_q;
      if (load) begin
        out_valid_d = 1'b1;
        out_data_d  = head[sel];
      end else begin
        out_valid_d = out_valid_q[o] && !out_ready[o];
        out_data_d  = out_data_q[o];
      end
    end

    always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
        ptr_q          <= '0;
        out_valid_q[o] <= 1'b0;
        out_data_q[o]  <= '0;
      end else begin
        ptr_q          <= ptr_d;
        out_valid_q[o] <= out_valid_d;
        out_data_q[o]  <= out_data_d;
      end
    end
  end

endmodule
